// File: rtl/ddr3_ui_arbiter_pkg.sv
// Shared definitions for the DDR3 UI arbiter: memory geometry, MIG command codes,
// FSM state encoding and grant tracking.
package ddr3_ui_arbiter_pkg;

  localparam int MEM_ADDR_SIZE = 28;
  localparam int CACHE_WIDTH   = 128;

  localparam logic [2:0] UI_CMD_WR = 3'b000;
  localparam logic [2:0] UI_CMD_RD = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2
  } state_e;

  typedef enum logic {
    GNT_WR = 1'b0,
    GNT_RD = 1'b1
  } grant_e;

endpackage

// File: rtl/ddr3_req_fifo.sv
// Synchronous request FIFO; pointers carry an extra MSB to tell full from empty.
// Pushes while full and pops while empty are ignored.
module ddr3_req_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage is not reset; emptiness is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/ddr3_ui_arbiter.sv
// Buffers DDR3 write/read request strobes and issues them one at a time on the MIG
// user interface; read data returns in MIG order as a registered strobe pair.
module ddr3_ui_arbiter
  import ddr3_ui_arbiter_pkg::*;
#(
  parameter int ADDR_W     = MEM_ADDR_SIZE,
  parameter int DATA_W     = CACHE_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_RD_OUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ddr3_wr_en,
  input  logic [ADDR_W-1:0] ddr3_wr_addr,
  input  logic [DATA_W-1:0] ddr3_wr_data,
  input  logic              ddr3_rd_req,
  input  logic [ADDR_W-1:0] ddr3_rd_addr,
  output logic              ddr3_din_en,
  output logic [DATA_W-1:0] ddr3_din,
  output logic              wr_ovf,
  output logic              rd_ovf,
  output logic              app_en,
  output logic [2:0]        app_cmd,
  output logic [ADDR_W-1:0] app_addr,
  input  logic              app_rdy,
  output logic              app_wdf_wren,
  output logic              app_wdf_end,
  output logic [DATA_W-1:0] app_wdf_data,
  input  logic              app_wdf_rdy,
  input  logic [DATA_W-1:0] app_rd_data,
  input  logic              app_rd_data_valid
);

  localparam int WF_W     = ADDR_W + DATA_W;
  localparam int RD_CNT_W = $clog2(MAX_RD_OUT) + 1;

  // Input capture stage
  logic              wr_en_q, rd_req_q;
  logic [ADDR_W-1:0] wr_addr_q, rd_addr_q;
  logic [DATA_W-1:0] wr_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_en_q  <= 1'b0;
      rd_req_q <= 1'b0;
    end else begin
      wr_en_q  <= ddr3_wr_en;
      rd_req_q <= ddr3_rd_req;
    end
    wr_addr_q <= ddr3_wr_addr;
    wr_data_q <= ddr3_wr_data;
    rd_addr_q <= ddr3_rd_addr;
  end

  // Request FIFOs
  logic              wr_pop, wr_full, wr_empty;
  logic              rd_pop, rd_full, rd_empty;
  logic [WF_W-1:0]   wr_dout;
  logic [ADDR_W-1:0] rd_dout;

  ddr3_req_fifo #(.WIDTH(WF_W), .DEPTH(FIFO_DEPTH)) u_wr_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_en_q),
    .pop   (wr_pop),
    .din   ({wr_addr_q, wr_data_q}),
    .dout  (wr_dout),
    .full  (wr_full),
    .empty (wr_empty)
  );

  ddr3_req_fifo #(.WIDTH(ADDR_W), .DEPTH(FIFO_DEPTH)) u_rd_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rd_req_q),
    .pop   (rd_pop),
    .din   (rd_addr_q),
    .dout  (rd_dout),
    .full  (rd_full),
    .empty (rd_empty)
  );

  // Arbitration FSM and UI output registers
  state_e              state_q, state_d;
  grant_e              last_grant_q, last_grant_d;
  logic                cmd_done_q, cmd_done_d;
  logic                dat_done_q, dat_done_d;
  logic [RD_CNT_W-1:0] rd_out_q, rd_out_d;
  logic                app_en_q, app_en_d;
  logic [2:0]          app_cmd_q, app_cmd_d;
  logic [ADDR_W-1:0]   app_addr_q, app_addr_d;
  logic                wren_q, wren_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                wr_ovf_q, wr_ovf_d;
  logic                rd_ovf_q, rd_ovf_d;
  logic                din_en_q;
  logic [DATA_W-1:0]   din_q;
  logic                rd_issue;
  logic                wr_elig, rd_elig;
  logic                cmd_acc, dat_acc;

  assign wr_elig = !wr_empty;
  assign rd_elig = !rd_empty && (rd_out_q < RD_CNT_W'(MAX_RD_OUT));
  assign cmd_acc = app_en_q && app_rdy;
  assign dat_acc = wren_q && app_wdf_rdy;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cmd_done_d   = cmd_done_q;
    dat_done_d   = dat_done_q;
    app_en_d     = app_en_q;
    app_cmd_d    = app_cmd_q;
    app_addr_d   = app_addr_q;
    wren_d       = wren_q;
    wdata_d      = wdata_q;
    wr_pop       = 1'b0;
    rd_pop       = 1'b0;
    rd_issue     = 1'b0;
    wr_ovf_d     = wr_ovf_q || (wr_en_q && wr_full);
    rd_ovf_d     = rd_ovf_q || (rd_req_q && rd_full);

    unique case (state_q)
      ST_IDLE: begin
        // last_grant only moves on contested decisions, so contested pairs alternate.
        if (wr_elig && (!rd_elig || last_grant_q == GNT_RD)) begin
          if (rd_elig) last_grant_d = GNT_WR;
          app_en_d   = 1'b1;
          app_cmd_d  = UI_CMD_WR;
          app_addr_d = wr_dout[WF_W-1:DATA_W];
          wren_d     = 1'b1;
          wdata_d    = wr_dout[DATA_W-1:0];
          state_d    = ST_WR;
        end else if (rd_elig) begin
          if (wr_elig) last_grant_d = GNT_RD;
          app_en_d   = 1'b1;
          app_cmd_d  = UI_CMD_RD;
          app_addr_d = rd_dout;
          state_d    = ST_RD;
        end
      end
      ST_WR: begin
        if (cmd_acc) app_en_d = 1'b0;
        if (dat_acc) wren_d = 1'b0;
        if ((cmd_done_q || cmd_acc) && (dat_done_q || dat_acc)) begin
          wr_pop     = 1'b1;
          cmd_done_d = 1'b0;
          dat_done_d = 1'b0;
          state_d    = ST_IDLE;
        end else begin
          cmd_done_d = cmd_done_q || cmd_acc;
          dat_done_d = dat_done_q || dat_acc;
        end
      end
      ST_RD: begin
        if (cmd_acc) begin
          app_en_d = 1'b0;
          rd_pop   = 1'b1;
          rd_issue = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    rd_out_d = rd_out_q;
    if (rd_issue && !app_rd_data_valid)
      rd_out_d = rd_out_q + 1'b1;
    else if (!rd_issue && app_rd_data_valid && rd_out_q != '0)
      rd_out_d = rd_out_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_grant_q <= GNT_RD;
      cmd_done_q   <= 1'b0;
      dat_done_q   <= 1'b0;
      rd_out_q     <= '0;
      app_en_q     <= 1'b0;
      app_cmd_q    <= 3'b000;
      app_addr_q   <= '0;
      wren_q       <= 1'b0;
      wdata_q      <= '0;
      wr_ovf_q     <= 1'b0;
      rd_ovf_q     <= 1'b0;
      din_en_q     <= 1'b0;
      din_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cmd_done_q   <= cmd_done_d;
      dat_done_q   <= dat_done_d;
      rd_out_q     <= rd_out_d;
      app_en_q     <= app_en_d;
      app_cmd_q    <= app_cmd_d;
      app_addr_q   <= app_addr_d;
      wren_q       <= wren_d;
      wdata_q      <= wdata_d;
      wr_ovf_q     <= wr_ovf_d;
      rd_ovf_q     <= rd_ovf_d;
      din_en_q     <= app_rd_data_valid;
      din_q        <= app_rd_data;
    end
  end

  assign app_en       = app_en_q;
  assign app_cmd      = app_cmd_q;
  assign app_addr     = app_addr_q;
  assign app_wdf_wren = wren_q;
  assign app_wdf_end  = wren_q;
  assign app_wdf_data = wdata_q;
  assign wr_ovf       = wr_ovf_q;
  assign rd_ovf       = rd_ovf_q;
  assign ddr3_din_en  = din_en_q;
  assign ddr3_din     = din_q;

endmodule

// File: doc/ddr3_ui_arbiter.md
# ddr3_ui_arbiter

Responder side of the DDR3 request interface. Accepts the fire-and-forget write (enable/address/data) and read (request/address) strobes from the DDR3 address controller, buffers them, and issues them one at a time as commands on the MIG user interface (UI). It returns MIG read data to the address controller as a `ddr3_din_en`/`ddr3_din` strobe pair. Sits between the DDR3 address controller and the MIG IP.

## Interface
- `ADDR_W`, 28: DDR3 byte address width (`MEM_ADDR_SIZE`).
- `DATA_W`, 128: data width (`CACHE_WIDTH`); equals the MIG UI data width, so one request is one UI beat.
- `FIFO_DEPTH`, 4: entries in each request FIFO. Must be a power of 2 and at least 2.
- `MAX_RD_OUT`, 16: maximum number of reads issued but not yet returned.

Ports:
- `clk`  in  1  sole clock. All logic is in this domain.
- `rst`  in  1  synchronous, active-high reset.
- `ddr3_wr_en`  in  1  write request strobe, one cycle per request.
- `ddr3_wr_addr`  in  ADDR_W  write address, qualified by `ddr3_wr_en`.
- `ddr3_wr_data`  in  DATA_W  write data, qualified by `ddr3_wr_en`.
- `ddr3_rd_req`  in  1  read request strobe.
- `ddr3_rd_addr`  in  ADDR_W  read address, qualified by `ddr3_rd_req`.
- `ddr3_din_en`  out  1  read data valid.
- `ddr3_din`  out  DATA_W  read data.
- `wr_ovf`, `rd_ovf`  out  1 each  sticky flag: a request was dropped because its FIFO was full.
- `app_en`, `app_cmd[2:0]`, `app_addr[ADDR_W-1:0]`  out  MIG command channel. `app_cmd` is 3'b000 for write, 3'b001 for read.
- `app_rdy`  in  1  MIG command accept.
- `app_wdf_wren`, `app_wdf_end`, `app_wdf_data[DATA_W-1:0]`  out  MIG write-data channel.
- `app_wdf_rdy`  in  1  MIG write-data accept.
- `app_rd_data[DATA_W-1:0]`, `app_rd_data_valid`  in  MIG read-return channel.

## Operation
Request capture:
- On `ddr3_wr_en`, push {addr, data} into the write FIFO. On `ddr3_rd_req`, push addr into the read FIFO.
- A push to a full FIFO is dropped and sets the matching `*_ovf` flag. The flag stays set until reset.
- Simultaneous write and read pushes are both accepted.

FSM with states IDLE, WR, RD:
- **IDLE**: select a request.
  - A read is eligible only if its FIFO is not empty and the outstanding-read count is below `MAX_RD_OUT`.
  - If both a write and a read are eligible, grant the opposite of `last_grant`. `last_grant` resets to RD, so the first contested grant goes to WR.
  - Load the FIFO head into the output registers and move to WR or RD.
- **WR**: drive `app_en`=1, `app_cmd`=000, the address, `app_wdf_wren`=`app_wdf_end`=1, and the data.
  - The command channel and the data channel complete independently. Flag `cmd_done` is set on `app_en&app_rdy`; flag `dat_done` is set on `app_wdf_wren&app_wdf_rdy`.
  - Each channel deasserts its own valid the cycle after its own accept.
  - When both flags are set, pop the write FIFO, clear both flags, and return to IDLE.
- **RD**: drive `app_en`=1 and `app_cmd`=001 until `app_rdy`. On accept, pop the read FIFO, increment the outstanding count, and return to IDLE.

Outstanding-read count:
- Width is clog2(`MAX_RD_OUT`)+1 bits.
- Decrements on `app_rd_data_valid`.
- A simultaneous issue and return leaves the count unchanged.

Read return:
- `ddr3_din_en` <= `app_rd_data_valid` and `ddr3_din` <= `app_rd_data`, registered.
- Data returns in MIG order. No reordering.

FIFO pointers are FIFO_DEPTH-indexed and wrap modulo the depth. Full and empty are decided by an extra pointer MSB.

## Timing
Reset values:
- All outputs 0.
- FSM in IDLE.
- FIFOs empty, outstanding count 0, `last_grant`=RD.
- Reset during WR or RD abandons the transaction. The next cycle shows `app_en`=0 and `app_wdf_wren`=0.

Latency:
- A request strobe sampled at edge N makes `app_en` high after edge N+2 (FIFO write, then IDLE decision), provided the FSM is in IDLE and no other request is queued.
- Minimum spacing between successive UI commands is 2 cycles (IDLE is revisited after each command).
- Read return: `app_rd_data_valid` at edge M gives `ddr3_din_en` high for the cycle after edge M.

Hold rules:
- `app_en` and `app_addr` must not change while `app_en`=1 and `app_rdy`=0.
- `app_wdf_*` must not change while `app_wdf_wren`=1 and `app_wdf_rdy`=0.

## Structure
- The shared defines supply `MEM_ADDR_SIZE` and `CACHE_WIDTH`.
- Add `UI_CMD_WR`/`UI_CMD_RD` (3'b000/3'b001) and the FSM state encoding to the shared package.
- One sub-module, `ddr3_req_fifo`: a synchronous FIFO with parameters WIDTH/DEPTH and ports push/pop/din/dout/full/empty.
  - Instantiate it twice: write FIFO WIDTH=ADDR_W+DATA_W, read FIFO WIDTH=ADDR_W.

## Test plan
- Single write 0x100, data 0xA5.., with `app_rdy`=`app_wdf_rdy`=1 → one `app_en` pulse with cmd 000, addr 0x100, `app_wdf_end`=1, 2 cycles after the strobe.
- Write with `app_wdf_rdy` held low 3 cycles, `app_rdy`=1 → command accepted and dropped immediately; data held stable for 3 cycles, then accepted; FIFO pops once.
- `ddr3_wr_en` and `ddr3_rd_req` in the same cycle, addresses 0x100/0x200 → WR issued first, then RD; with a second contested pair, RD/WR order alternates.
- 5 back-to-back writes with `app_rdy`=0 (DEPTH=4) → 4 stored, `wr_ovf`=1; after `app_rdy`=1, exactly 4 writes issued in order.
- 17 reads with no returned data (MAX_RD_OUT=16) → 16 issued, `app_en` stays low; one `app_rd_data_valid` → 17th issued; `ddr3_din` equals `app_rd_data` one cycle later.
- Assert `rst` mid-WR with `app_rdy`=0 → next cycle all outputs 0, both `*_ovf` cleared; a new write afterwards issues normally.
